// File: rtl/radio_frame_deserializer_if.sv
// Signal bundle between the serial radio sample stream and the deserializer.
// The master side drives the serial bit and sync marker; the slave side returns decoded frames.
interface radio_frame_deserializer_if #(
   parameter int ERR_W = 16
);
   logic             DATA_IN;
   logic             SYNC_IN;
   logic [7:0]       WORD_OUT;
   logic [1:0]       R0_I_OUT;
   logic [1:0]       R0_Q_OUT;
   logic [1:0]       R1_I_OUT;
   logic [1:0]       R1_Q_OUT;
   logic             WORD_VALID;
   logic             LOCKED;
   logic [ERR_W-1:0] SYNC_ERR_COUNT;

   modport master (
      output DATA_IN,
      output SYNC_IN,
      input  WORD_OUT,
      input  R0_I_OUT,
      input  R0_Q_OUT,
      input  R1_I_OUT,
      input  R1_Q_OUT,
      input  WORD_VALID,
      input  LOCKED,
      input  SYNC_ERR_COUNT
   );

   modport slave (
      input  DATA_IN,
      input  SYNC_IN,
      output WORD_OUT,
      output R0_I_OUT,
      output R0_Q_OUT,
      output R1_I_OUT,
      output R1_Q_OUT,
      output WORD_VALID,
      output LOCKED,
      output SYNC_ERR_COUNT
   );
endinterface

// File: rtl/radio_frame_deserializer.sv
// Aligns the 1-bit radio sample stream to 8-bit frames using the SYNC marker and emits
// {R0_I, R0_Q, R1_I, R1_Q} words while locked; a flywheel rides through isolated missing syncs.
module radio_frame_deserializer #(
   parameter int LOCK_FRAMES = 4,
   parameter int MISS_LIMIT  = 2,
   parameter int ERR_W       = 16
) (
   input logic                        SYS_CLK,
   input logic                        RST_N,
   radio_frame_deserializer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_CHECK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] LP_LOCK_FRAMES = 4'(LOCK_FRAMES);
   localparam logic [3:0] LP_MISS_LIMIT  = 4'(MISS_LIMIT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [2:0]       r_bit_cnt;
   logic [2:0]       w_bit_cnt_nxt;
   logic [7:0]       r_shift;
   logic [7:0]       w_shift_nxt;
   logic [7:0]       r_word;
   logic [7:0]       w_word_nxt;
   logic             r_valid;
   logic             w_valid_nxt;
   logic             r_locked;
   logic [3:0]       r_good;
   logic [3:0]       w_good_nxt;
   logic [3:0]       r_miss;
   logic [3:0]       w_miss_nxt;
   logic [ERR_W-1:0] r_err;
   logic [ERR_W-1:0] w_err_nxt;

   logic             w_err_inc;
   logic             w_slot;
   logic [3:0]       w_good_inc;
   logic [3:0]       w_miss_inc;
   logic [7:0]       w_shift_ld;
   logic [7:0]       w_shift_realign;

   assign w_slot          = (r_bit_cnt == 3'd0);
   assign w_good_inc      = r_good + 4'd1;
   assign w_miss_inc      = r_miss + 4'd1;
   assign w_shift_realign = {7'd0, bus.DATA_IN};

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
   always_comb begin
      w_shift_ld            = r_shift;
      w_shift_ld[r_bit_cnt] = bus.DATA_IN;

      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_word_nxt    = r_word;
      w_valid_nxt   = 1'b0;
      w_good_nxt    = r_good;
      w_miss_nxt    = r_miss;
      w_err_inc     = 1'b0;

      unique case (r_state)
         ST_HUNT: begin
            w_bit_cnt_nxt = 3'd0;
            if (bus.SYNC_IN) begin
               w_shift_nxt   = w_shift_realign;
               w_bit_cnt_nxt = 3'd1;
               w_good_nxt    = 4'd0;
               w_state_nxt   = ST_CHECK;
            end
         end

         ST_CHECK: begin
            if (w_slot) begin
               if (bus.SYNC_IN) begin
                  w_shift_nxt   = w_shift_ld;
                  w_bit_cnt_nxt = 3'd1;
                  w_good_nxt    = w_good_inc;
                  if (w_good_inc == LP_LOCK_FRAMES) begin
                     w_state_nxt = ST_LOCKED;
                     w_miss_nxt  = 4'd0;
                  end
               end else begin
                  w_state_nxt   = ST_HUNT;
                  w_bit_cnt_nxt = 3'd0;
                  w_err_inc     = 1'b1;
               end
            end else if (bus.SYNC_IN) begin
               w_shift_nxt   = w_shift_realign;
               w_bit_cnt_nxt = 3'd1;
               w_good_nxt    = 4'd0;
               w_err_inc     = 1'b1;
            end else begin
               w_shift_nxt   = w_shift_ld;
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end
         end

         ST_LOCKED: begin
            if (bus.SYNC_IN && !w_slot) begin
               // Misplaced marker: the partial word is dropped and alignment restarts here.
               w_shift_nxt   = w_shift_realign;
               w_bit_cnt_nxt = 3'd1;
               w_good_nxt    = 4'd0;
               w_err_inc     = 1'b1;
               w_state_nxt   = ST_CHECK;
            end else begin
               w_shift_nxt   = w_shift_ld;
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_word_nxt  = {bus.DATA_IN, r_shift[6:0]};
                  w_valid_nxt = 1'b1;
               end
               if (w_slot) begin
                  if (bus.SYNC_IN) begin
                     w_miss_nxt = 4'd0;
                  end else begin
                     w_miss_nxt = w_miss_inc;
                     w_err_inc  = 1'b1;
                     if (w_miss_inc == LP_MISS_LIMIT) begin
                        w_state_nxt   = ST_HUNT;
                        w_bit_cnt_nxt = 3'd0;
                     end
                  end
               end
            end
         end

         default: begin
            w_state_nxt   = ST_HUNT;
            w_bit_cnt_nxt = 3'd0;
         end
      endcase

      w_err_nxt = (w_err_inc && (r_err != '1)) ? r_err + 1'b1 : r_err;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state   <= ST_HUNT;
         r_bit_cnt <= 3'd0;
         r_shift   <= 8'd0;
         r_word    <= 8'd0;
         r_valid   <= 1'b0;
         r_locked  <= 1'b0;
         r_good    <= 4'd0;
         r_miss    <= 4'd0;
         r_err     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_word    <= w_word_nxt;
         r_valid   <= w_valid_nxt;
         r_locked  <= (w_state_nxt == ST_LOCKED);
         r_good    <= w_good_nxt;
         r_miss    <= w_miss_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign bus.WORD_OUT       = r_word;
   assign bus.R0_I_OUT       = r_word[7:6];
   assign bus.R0_Q_OUT       = r_word[5:4];
   assign bus.R1_I_OUT       = r_word[3:2];
   assign bus.R1_Q_OUT       = r_word[1:0];
   assign bus.WORD_VALID     = r_valid;
   assign bus.LOCKED         = r_locked;
   assign bus.SYNC_ERR_COUNT = r_err;

endmodule

// File: tb/tb_radio_frame_deserializer.sv
// Directed bench for radio_frame_deserializer: expected words are queued as frames are sent
// and popped when WORD_VALID strobes; a second instance with a 4-bit error counter checks saturation.
module tb_radio_frame_deserializer;

   logic SYS_CLK;
   logic RST_N;

   radio_frame_deserializer_if #(.ERR_W(16)) b1 ();
   radio_frame_deserializer_if #(.ERR_W(4))  b2 ();

   radio_frame_deserializer #(.LOCK_FRAMES(4), .MISS_LIMIT(2), .ERR_W(16)) u_dut (
      .SYS_CLK (SYS_CLK),
      .RST_N   (RST_N),
      .bus     (b1.slave)
   );

   radio_frame_deserializer #(.LOCK_FRAMES(4), .MISS_LIMIT(2), .ERR_W(4)) u_dut_sat (
      .SYS_CLK (SYS_CLK),
      .RST_N   (RST_N),
      .bus     (b2.slave)
   );

   int         n_cmp = 0;
   int         n_mis = 0;
   logic [7:0] sb[$];
   logic [7:0] pat[3];
   int         fi;

   initial begin
      SYS_CLK = 1'b0;
      forever #5 SYS_CLK = ~SYS_CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive the main stream, then look at the outputs 1 ns after the edge.
   task automatic step(input logic d, input logic s);
      logic [7:0] e;
      b1.DATA_IN = d;
      b1.SYNC_IN = s;
      @(posedge SYS_CLK);
      #1;
      if (b1.WORD_VALID !== 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 32'(b1.WORD_VALID), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("word_out", 32'(b1.WORD_OUT), 32'(e));
            chk("r0_i", 32'(b1.R0_I_OUT), 32'(e[7:6]));
            chk("r0_q", 32'(b1.R0_Q_OUT), 32'(e[5:4]));
            chk("r1_i", 32'(b1.R1_I_OUT), 32'(e[3:2]));
            chk("r1_q", 32'(b1.R1_Q_OUT), 32'(e[1:0]));
         end
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic s, input logic emit, input logic lock_exp);
      for (int i = 0; i < 8; i++) begin
         if (i == 7 && emit) sb.push_back(b);
         step(b[i], (i == 0) ? s : 1'b0);
         if (i == 0) chk("locked_at_bit0", 32'(b1.LOCKED), 32'(lock_exp));
      end
      chk("word_strobe_seen", 32'(sb.size()), 32'd0);
   endtask

   task automatic send_pat(input logic s, input logic emit, input logic lock_exp);
      send_frame(pat[fi % 3], s, emit, lock_exp);
      fi++;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_word"},   32'(b1.WORD_OUT), 32'd0);
      chk({tag, "_valid"},  32'(b1.WORD_VALID), 32'd0);
      chk({tag, "_locked"}, 32'(b1.LOCKED), 32'd0);
      chk({tag, "_err"},    32'(b1.SYNC_ERR_COUNT), 32'd0);
   endtask

   initial begin
      pat[0] = 8'h00;
      pat[1] = 8'hA5;
      pat[2] = 8'h3C;
      fi     = 0;

      RST_N      = 1'b0;
      b1.DATA_IN = 1'b0;
      b1.SYNC_IN = 1'b0;
      b2.DATA_IN = 1'b0;
      b2.SYNC_IN = 1'b0;
      #1;
      chk_zero_outputs("reset");
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk_zero_outputs("reset_held");
      RST_N = 1'b1;

      // Saturation: a held SYNC makes every clock after the first a misplaced marker.
      b2.SYNC_IN = 1'b1;
      repeat (8) step(1'b0, 1'b0);
      chk("sat_count_7", 32'(b2.SYNC_ERR_COUNT), 32'd7);
      repeat (8) step(1'b0, 1'b0);
      chk("sat_count_15", 32'(b2.SYNC_ERR_COUNT), 32'd15);
      repeat (5) step(1'b0, 1'b0);
      chk("sat_hold_15", 32'(b2.SYNC_ERR_COUNT), 32'd15);
      b2.SYNC_IN = 1'b0;
      repeat (10) step(1'b0, 1'b0);
      chk("sat_no_wrap", 32'(b2.SYNC_ERR_COUNT), 32'd15);
      chk("main_idle_unlocked", 32'(b1.LOCKED), 32'd0);

      // Clean acquisition: LOCKED at the 5th sync, words from that frame on.
      for (int k = 0; k < 8; k++) send_pat(1'b1, k >= 4, k >= 4);
      chk("clean_err", 32'(b1.SYNC_ERR_COUNT), 32'd0);

      // Single dropped markers are ridden through.
      send_pat(1'b0, 1'b1, 1'b1);
      chk("drop1_err", 32'(b1.SYNC_ERR_COUNT), 32'd1);
      send_pat(1'b1, 1'b1, 1'b1);
      send_pat(1'b0, 1'b1, 1'b1);
      chk("drop1b_err", 32'(b1.SYNC_ERR_COUNT), 32'd2);
      send_pat(1'b1, 1'b1, 1'b1);

      // Two consecutive misses unlock at the second slot; relock needs 4 frames after a sync.
      send_pat(1'b0, 1'b1, 1'b1);
      send_pat(1'b0, 1'b0, 1'b0);
      chk("drop2_err", 32'(b1.SYNC_ERR_COUNT), 32'd4);
      send_pat(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) send_pat(1'b1, k >= 4, k >= 4);
      chk("relock_err", 32'(b1.SYNC_ERR_COUNT), 32'd4);

      // Shift alignment by 3 bits: sync lands at bit_cnt=3.
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      chk("shift_still_locked", 32'(b1.LOCKED), 32'd1);
      for (int k = 0; k < 7; k++) send_pat(1'b1, k >= 4, k >= 4);
      chk("shift_err", 32'(b1.SYNC_ERR_COUNT), 32'd5);

      // Asynchronous reset in the middle of a locked frame.
      send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
      chk("pre_reset_word", 32'(b1.WORD_OUT), 32'hA5);
      step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      chk_zero_outputs("async_reset");
      #1;
      RST_N = 1'b1;
      send_pat(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) send_pat(1'b1, k >= 4, k >= 4);
      chk("post_reset_err", 32'(b1.SYNC_ERR_COUNT), 32'd0);
      chk("post_reset_locked", 32'(b1.LOCKED), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
